operand_forward_unit: RTL

Parametrised operand bypass network for the execute stage: resolves each source operand of the instruction in execute from NSTAGES in-flight producer stages, the write-back port, or the register value latched into the ID/EX pipeline register. Adds load-use stall detection and a per-port capture buffer so that values forwarded while execute is held are not lost when their producer retires.

---
 rtl/operand_forward_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/operand_forward_unit.sv
// Execute-stage operand bypass network with load-use stall detection and a
// per-port capture buffer. Optional stall-cycle counter enabled by FWD_PERF_EN.
module operand_forward_unit #(
  parameter int NPORTS  = 2,
  parameter int NSTAGES = 2,
  parameter int XLEN    = 64,
  parameter int RADDR   = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NPORTS*RADDR-1:0]   src_addr,
  input  logic [NPORTS*XLEN-1:0]    src_data,
  input  logic                      hold,
  input  logic [NSTAGES-1:0]        p_valid,
  input  logic [NSTAGES*RADDR-1:0]  p_rd,
  input  logic [NSTAGES-1:0]        p_ready,
  input  logic [NSTAGES*XLEN-1:0]   p_data,
  input  logic                      wb_valid,
  input  logic [RADDR-1:0]          wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  output logic [NPORTS*XLEN-1:0]    op_data,
  output logic                      stall_req
`ifdef FWD_PERF_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  logic [NPORTS-1:0] hazard;

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      logic [RADDR-1:0] addr;
      logic [XLEN-1:0]  reg_val;
      logic             cap_valid_reg;
      logic [XLEN-1:0]  cap_data_reg;
      logic             stage_hit;
      logic             stage_rdy;
      logic [XLEN-1:0]  stage_val;
      logic             fwd;
      logic             haz;
      logic [XLEN-1:0]  val;

      assign addr    = src_addr[gi*RADDR +: RADDR];
      assign reg_val = src_data[gi*XLEN +: XLEN];

      // Scan oldest to youngest so the youngest matching stage wins.
      always_comb begin
        stage_hit = 1'b0;
        stage_rdy = 1'b0;
        stage_val = '0;
        for (int s = NSTAGES - 1; s >= 0; s--) begin
          if (p_valid[s] && (p_rd[s*RADDR +: RADDR] == addr)) begin
            stage_hit = 1'b1;
            stage_rdy = p_ready[s];
            stage_val = p_data[s*XLEN +: XLEN];
          end
        end
      end

      always_comb begin
        fwd = 1'b0;
        haz = 1'b0;
        val = cap_valid_reg ? cap_data_reg : reg_val;
        if (addr == '0) begin
          val = '0;
        end else if (stage_hit) begin
          if (stage_rdy) begin
            fwd = 1'b1;
            val = stage_val;
          end else begin
            haz = 1'b1;
          end
        end else if (wb_valid && (wb_rd == addr)) begin
          fwd = 1'b1;
          val = wb_data;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cap_valid_reg <= 1'b0;
          cap_data_reg  <= '0;
        end else if (hold) begin
          if (fwd) begin
            cap_valid_reg <= 1'b1;
            cap_data_reg  <= val;
          end
        end else begin
          cap_valid_reg <= 1'b0;
        end
      end

      assign op_data[gi*XLEN +: XLEN] = val;
      assign hazard[gi]               = haz;
    end
  endgenerate

  assign stall_req = |hazard;

`ifdef FWD_PERF_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_reg <= '0;
    end else if (stall_req && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
`endif

endmodule
